axi4_ar_drop_sender: RTL and testbench

- Read-address stage directly upstream of the read-response sender.
- Captures one AR request from the slave port and presents its address to the RAB lookup.
- On an accept decision, forwards the AR with the translated address to the master port.
- On a drop decision or lookup timeout, consumes the AR locally and hands its ID to the response sender via trans_id/trans_drop, so the response sender returns a single SLVERR beat.

---
 rtl/axi4_ar_drop_sender.sv | 161 ++++++++++++++++
 tb/tb_axi4_ar_drop_sender.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_ar_drop_sender.sv
// Read-address stage: captures one AR, asks the RAB for a decision, then either forwards
// the translated AR downstream or retires it locally by handing its ID to the response sender.
module axi4_ar_drop_sender #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int LOOKUP_TIMEOUT = 0
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
  input  logic [7:0]                s_axi4_arlen,
  input  logic [2:0]                s_axi4_arsize,
  input  logic [1:0]                s_axi4_arburst,
  input  logic                      s_axi4_arlock,
  input  logic [2:0]                s_axi4_arprot,
  input  logic [3:0]                s_axi4_arcache,
  input  logic [AXI_USER_WIDTH-1:0] s_axi4_aruser,
  input  logic                      s_axi4_arvalid,
  output logic                      s_axi4_arready,
  output logic                      lookup_valid,
  output logic [AXI_ADDR_WIDTH-1:0] lookup_addr,
  output logic [AXI_ID_WIDTH-1:0]   lookup_id,
  input  logic                      lookup_accept,
  input  logic                      lookup_drop,
  input  logic [AXI_ADDR_WIDTH-1:0] lookup_paddr,
  output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic [7:0]                m_axi4_arlen,
  output logic [2:0]                m_axi4_arsize,
  output logic [1:0]                m_axi4_arburst,
  output logic                      m_axi4_arlock,
  output logic [2:0]                m_axi4_arprot,
  output logic [3:0]                m_axi4_arcache,
  output logic [AXI_USER_WIDTH-1:0] m_axi4_aruser,
  output logic                      m_axi4_arvalid,
  input  logic                      m_axi4_arready,
  output logic [AXI_ID_WIDTH-1:0]   trans_id,
  output logic                      trans_drop,
  input  logic                      trans_drop_ready
);

  localparam int CNT_W = (LOOKUP_TIMEOUT > 0) ? $clog2(LOOKUP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_lock;
  logic [2:0]                r_prot;
  logic [3:0]                r_cache;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic [CNT_W-1:0]          r_cnt;

  logic w_cap;
  logic w_acc;
  logic w_clr;
  logic w_cnt_en;
  logic w_timeout;

  // Drop wins over accept; the timeout only fires when neither decision is present.
  assign w_cap     = (r_state == IDLE) & s_axi4_arvalid;
  assign w_acc     = (r_state == LOOKUP) & lookup_accept & ~lookup_drop;
  assign w_cnt_en  = (r_state == LOOKUP) & ~lookup_accept & ~lookup_drop & (LOOKUP_TIMEOUT > 0);
  assign w_timeout = (LOOKUP_TIMEOUT > 0) && (r_cnt == CNT_W'(LOOKUP_TIMEOUT - 1));
  assign w_clr     = axi4_arst
                   | ((r_state == SEND) & m_axi4_arready)
                   | ((r_state == DROP) & trans_drop_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (s_axi4_arvalid) w_next = LOOKUP;
        else                w_next = IDLE;
      end
      LOOKUP: begin
        if (lookup_drop)        w_next = DROP;
        else if (lookup_accept) w_next = SEND;
        else if (w_timeout)     w_next = DROP;
        else                    w_next = LOOKUP;
      end
      SEND: begin
        if (m_axi4_arready) w_next = IDLE;
        else                w_next = SEND;
      end
      DROP: begin
        if (trans_drop_ready) w_next = IDLE;
        else                  w_next = DROP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Capture registers are zeroed whenever the entry retires so IDLE always shows clean outputs.
  always_ff @(posedge axi4_aclk) begin
    if (w_clr) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_lock  <= 1'b0;
      r_prot  <= 3'd0;
      r_cache <= 4'd0;
      r_user  <= '0;
    end else if (w_cap) begin
      r_id    <= s_axi4_arid;
      r_addr  <= s_axi4_araddr;
      r_len   <= s_axi4_arlen;
      r_size  <= s_axi4_arsize;
      r_burst <= s_axi4_arburst;
      r_lock  <= s_axi4_arlock;
      r_prot  <= s_axi4_arprot;
      r_cache <= s_axi4_arcache;
      r_user  <= s_axi4_aruser;
    end else if (w_acc) begin
      r_addr  <= lookup_paddr;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (w_clr || w_cap) r_cnt <= '0;
    else if (w_cnt_en)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign s_axi4_arready = (r_state == IDLE);
  assign lookup_valid   = (r_state == LOOKUP);
  assign m_axi4_arvalid = (r_state == SEND);
  assign trans_drop     = (r_state == DROP) & trans_drop_ready;

  assign lookup_addr    = r_addr;
  assign lookup_id      = r_id;
  assign trans_id       = r_id;
  assign m_axi4_arid    = r_id;
  assign m_axi4_araddr  = r_addr;
  assign m_axi4_arlen   = r_len;
  assign m_axi4_arsize  = r_size;
  assign m_axi4_arburst = r_burst;
  assign m_axi4_arlock  = r_lock;
  assign m_axi4_arprot  = r_prot;
  assign m_axi4_arcache = r_cache;
  assign m_axi4_aruser  = r_user;

endmodule

// File: tb/tb_axi4_ar_drop_sender.sv
// Randomized scoreboard bench: the driver predicts each AR's fate and timing, a monitor checks outputs.
module tb_axi4_ar_drop_sender;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arlock;
  logic [2:0]  s_arprot;
  logic [3:0]  s_arcache;
  logic [3:0]  s_aruser;
  logic        s_arvalid;
  logic        s_arready;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic [3:0]  lookup_id;
  logic        lookup_accept;
  logic        lookup_drop;
  logic [31:0] lookup_paddr;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arlock;
  logic [2:0]  m_arprot;
  logic [3:0]  m_arcache;
  logic [3:0]  m_aruser;
  logic        m_arvalid;
  logic        m_arready;
  logic [3:0]  trans_id;
  logic        trans_drop;
  logic        trans_drop_ready;

  axi4_ar_drop_sender #(.LOOKUP_TIMEOUT(TO)) dut (
    .axi4_aclk(clk), .axi4_arst(arst),
    .s_axi4_arid(s_arid), .s_axi4_araddr(s_araddr), .s_axi4_arlen(s_arlen),
    .s_axi4_arsize(s_arsize), .s_axi4_arburst(s_arburst), .s_axi4_arlock(s_arlock),
    .s_axi4_arprot(s_arprot), .s_axi4_arcache(s_arcache), .s_axi4_aruser(s_aruser),
    .s_axi4_arvalid(s_arvalid), .s_axi4_arready(s_arready),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_id(lookup_id),
    .lookup_accept(lookup_accept), .lookup_drop(lookup_drop), .lookup_paddr(lookup_paddr),
    .m_axi4_arid(m_arid), .m_axi4_araddr(m_araddr), .m_axi4_arlen(m_arlen),
    .m_axi4_arsize(m_arsize), .m_axi4_arburst(m_arburst), .m_axi4_arlock(m_arlock),
    .m_axi4_arprot(m_arprot), .m_axi4_arcache(m_arcache), .m_axi4_aruser(m_aruser),
    .m_axi4_arvalid(m_arvalid), .m_axi4_arready(m_arready),
    .trans_id(trans_id), .trans_drop(trans_drop), .trans_drop_ready(trans_drop_ready)
  );

  typedef struct {
    bit          fwd;
    logic [60:0] fields;  // {id, addr, len, size, burst, lock, prot, cache, user}
    logic [3:0]  id;
    int          start;
    int          done;
  } exp_t;

  exp_t        sb[$];
  bit          seen;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cur_vaddr;
  logic [3:0]  cur_id;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic junk_s();
    s_arid   = 4'($urandom);
    s_araddr = $urandom;
    s_arlen  = 8'($urandom);
  endtask

  // kind: 0 accept, 1 drop, 2 accept+drop, 3 no decision; d = LOOKUP cycle of the decision;
  // w = cycles of downstream/drop-ready back-pressure.
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input int kind, input int d, input logic [31:0] paddr, input int w);
    int   dd;
    bit   fwd;
    int   c;
    exp_t e;
    if (kind == 3 || d >= TO) begin
      dd = TO - 1; fwd = 1'b0;
    end else begin
      dd = d; fwd = (kind == 0);
    end
    @(negedge clk);
    s_arid = id; s_araddr = addr; s_arlen = len;
    s_arsize = 3'($urandom); s_arburst = 2'($urandom); s_arlock = 1'($urandom);
    s_arprot = 3'($urandom); s_arcache = 4'($urandom); s_aruser = 4'($urandom);
    s_arvalid = 1'b1;
    lookup_accept = 1'($urandom); lookup_drop = 1'($urandom); lookup_paddr = $urandom;
    m_arready = 1'($urandom); trans_drop_ready = 1'($urandom);
    c = cyc + 1;
    e.fwd    = fwd;
    e.id     = id;
    e.fields = {id, fwd ? paddr : addr, len, s_arsize, s_arburst, s_arlock,
                s_arprot, s_arcache, s_aruser};
    e.start  = c + dd + 1;
    e.done   = c + dd + 1 + w;
    sb.push_back(e);
    cur_vaddr = addr; cur_id = id;
    for (int k = 0; k <= dd; k++) begin
      @(negedge clk);
      s_arvalid = 1'($urandom); junk_s();
      lookup_accept = 1'b0; lookup_drop = 1'b0; lookup_paddr = $urandom;
      m_arready = 1'($urandom); trans_drop_ready = 1'($urandom);
      if (k == d && kind != 3) begin
        lookup_accept = (kind == 0 || kind == 2);
        lookup_drop   = (kind == 1 || kind == 2);
        lookup_paddr  = paddr;
      end
      #1;
      chk("lookup_busy", {s_arready, lookup_valid}, 2'b01);
    end
    for (int j = 0; j <= w; j++) begin
      @(negedge clk);
      s_arvalid = (j < w) ? 1'($urandom) : 1'b0; junk_s();
      lookup_accept = 1'($urandom); lookup_drop = 1'($urandom); lookup_paddr = $urandom;
      if (fwd) begin
        m_arready = (j == w); trans_drop_ready = 1'($urandom);
      end else begin
        trans_drop_ready = (j == w); m_arready = 1'($urandom);
      end
      #1;
      chk("arready_busy", s_arready, 1'b0);
    end
    @(negedge clk);
    s_arvalid = 1'b0; lookup_accept = 1'b0; lookup_drop = 1'b0;
    m_arready = 1'b0; trans_drop_ready = 1'b0;
    #1;
    chk("back_to_idle", {s_arready, lookup_valid, m_arvalid, trans_drop}, 4'b1000);
  endtask

  // Monitor: compares every presented output against the head of the scoreboard.
  initial begin
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (arst !== 1'b1) begin
        if (lookup_valid)
          chk("lookup_addr_id", {lookup_id, lookup_addr}, {cur_id, cur_vaddr});
        if (m_arvalid || trans_drop) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", {m_arvalid, trans_drop}, 2'b00);
          end else begin
            chk("out_type", {m_arvalid, trans_drop}, sb[0].fwd ? 2'b10 : 2'b01);
            if (m_arvalid) begin
              chk("m_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                               m_arprot, m_arcache, m_aruser}, sb[0].fields);
              if (!seen) chk("m_valid_cycle", cyc, sb[0].start);
              seen = 1'b1;
              if (m_arready) begin
                chk("m_handshake_cycle", cyc, sb[0].done);
                void'(sb.pop_front());
                seen = 1'b0;
              end
            end else begin
              chk("trans_id", trans_id, sb[0].id);
              chk("drop_cycle", cyc, sb[0].done);
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    arst = 1'b1; s_arvalid = 1'b0; junk_s();
    s_arsize = 3'd0; s_arburst = 2'd0; s_arlock = 1'b0; s_arprot = 3'd0;
    s_arcache = 4'd0; s_aruser = 4'd0;
    lookup_accept = 1'b0; lookup_drop = 1'b0; lookup_paddr = 32'd0;
    m_arready = 1'b0; trans_drop_ready = 1'b0;
    cur_vaddr = 32'd0; cur_id = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {s_arready, lookup_valid, m_arvalid, trans_drop}, 4'b1000);
    chk("reset_data", {m_arid, m_araddr, m_arlen, trans_id}, 48'd0);
    @(negedge clk);
    arst = 1'b0;

    do_ar(4'd3, 32'h1000_0040, 8'd7, 0, 0, 32'h8000_0040, 0);  // accept
    do_ar(4'd5, 32'h2000_0000, 8'd1, 1, 0, 32'h0,         0);  // drop
    do_ar(4'd6, 32'h2000_0100, 8'd2, 1, 1, 32'h0,         4);  // drop, ready held low 4 cycles
    do_ar(4'd7, 32'h3000_0000, 8'd3, 2, 0, 32'h9000_0000, 0);  // accept+drop -> drop
    do_ar(4'd8, 32'h4000_0000, 8'd0, 3, 0, 32'h0,         0);  // timeout
    do_ar(4'd9, 32'h5000_0000, 8'd4, 2, 3, 32'h9100_0000, 0);  // decision on last LOOKUP cycle
    do_ar(4'd10, 32'h6000_0000, 8'd5, 0, 3, 32'hA000_0000, 6); // downstream stall

    for (int i = 0; i < 60; i++)
      do_ar(4'($urandom), $urandom, 8'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 5), $urandom, $urandom_range(0, 3));

    // Reset while the AR sits stalled in SEND: it must never be emitted.
    @(negedge clk);
    s_arid = 4'd12; s_araddr = 32'h7000_0000; s_arlen = 8'd1; s_arvalid = 1'b1;
    cur_vaddr = 32'h7000_0000; cur_id = 4'd12;
    e.fwd = 1'b1; e.id = 4'd12; e.start = cyc + 2; e.done = -1;
    e.fields = {4'd12, 32'hB000_0000, 8'd1, s_arsize, s_arburst, s_arlock,
                s_arprot, s_arcache, s_aruser};
    sb.push_back(e);
    @(negedge clk);
    s_arvalid = 1'b0; lookup_accept = 1'b1; lookup_paddr = 32'hB000_0000;
    repeat (2) begin
      @(negedge clk);
      lookup_accept = 1'($urandom); lookup_drop = 1'($urandom); m_arready = 1'b0;
    end
    @(negedge clk);
    arst = 1'b1; m_arready = 1'b1; lookup_accept = 1'b0; lookup_drop = 1'b0;
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("after_reset", {s_arready, m_arvalid, trans_drop}, 3'b100);
    repeat (4) @(negedge clk);
    m_arready = 1'b0;
    do_ar(4'd13, 32'h7100_0000, 8'd2, 0, 1, 32'hC000_0000, 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
